// File: rtl/ifu_if.sv
// Instruction-memory fetch bus: one request/grant handshake, response returns later on rvalid.
interface ifu_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: single outstanding fetch, registered inst output, redirect/halt/fault control.
// Latency: REQ -> WAIT -> HOLD per word; inst is held in HOLD until inst_ready, no new request meanwhile.
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clock,
  input  logic        reset,
  ifu_if.master       imem,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        fault
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] REQ  = 3'd1;
  localparam logic [2:0] WAIT = 3'd2;
  localparam logic [2:0] HOLD = 3'd3;
  localparam logic [2:0] STOP = 3'd4;

  logic [2:0]  state;
  logic [31:0] fetch_pc;
  logic        drop;
  logic        halted;
  logic        redir_bad;

  assign redir_bad      = redirect && (redirect_pc[1:0] != 2'b00);
  assign imem.imem_req  = (state == REQ);
  assign imem.imem_addr = fetch_pc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      fetch_pc   <= RESET_PC;
      inst       <= '0;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
      drop       <= 1'b0;
      halted     <= 1'b0;
      fault      <= 1'b0;
    end else begin
      if (halt) halted <= 1'b1;
      case (state)
        IDLE: begin
          if (halt) begin
            state <= STOP;
          end else if (redir_bad) begin
            fault <= 1'b1;
            state <= STOP;
          end else begin
            if (redirect) fetch_pc <= redirect_pc;
            state <= REQ;
          end
        end
        REQ: begin
          // a granted request must still be drained even when halting
          if (halt) begin
            state <= imem.imem_gnt ? WAIT : STOP;
          end else if (redir_bad) begin
            fault <= 1'b1;
            state <= STOP;
          end else begin
            if (redirect) fetch_pc <= redirect_pc;
            if (imem.imem_gnt) begin
              drop  <= redirect;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (halt || halted) begin
            if (imem.imem_rvalid) state <= STOP;
          end else if (redir_bad) begin
            fault <= 1'b1;
            drop  <= 1'b0;
            state <= STOP;
          end else if (redirect) begin
            fetch_pc <= redirect_pc;
            drop     <= !imem.imem_rvalid;
            if (imem.imem_rvalid) state <= REQ;
          end else if (imem.imem_rvalid) begin
            drop <= 1'b0;
            if (drop) begin
              state <= REQ;
            end else begin
              inst       <= imem.imem_rdata;
              inst_pc    <= fetch_pc;
              inst_valid <= 1'b1;
              state      <= HOLD;
            end
          end
        end
        HOLD: begin
          if (halt) begin
            inst_valid <= 1'b0;
            state      <= STOP;
          end else if (redir_bad) begin
            inst_valid <= 1'b0;
            fault      <= 1'b1;
            state      <= STOP;
          end else if (redirect) begin
            inst_valid <= 1'b0;
            fetch_pc   <= redirect_pc;
            state      <= REQ;
          end else if (inst_ready) begin
            inst_valid <= 1'b0;
            fetch_pc   <= fetch_pc + 32'd4;
            state      <= REQ;
          end
        end
        default: state <= STOP;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: directed scenarios, then a randomized memory/decoder/redirect run against a PC-stream model.
module tb_ifu;
  logic        clock;
  logic        reset;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [31:0] inst, inst_pc, inst2, inst_pc2;
  logic        inst_valid, inst_valid2, fault, fault2;

  int errors = 0;
  int checks = 0;

  ifu_if m();
  ifu_if m2();

  assign m2.imem_gnt    = m.imem_gnt;
  assign m2.imem_rvalid = m.imem_rvalid;
  assign m2.imem_rdata  = m.imem_rdata;

  ifu dut (
    .clock(clock), .reset(reset), .imem(m.master),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt), .fault(fault)
  );

  ifu #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clock(clock), .reset(reset), .imem(m2.master),
    .inst(inst2), .inst_pc(inst_pc2), .inst_valid(inst_valid2), .inst_ready(inst_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt), .fault(fault2)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    m.imem_gnt    = 1'b0;
    m.imem_rvalid = 1'b0;
    m.imem_rdata  = 32'h0;
    inst_ready    = 1'b0;
    redirect      = 1'b0;
    redirect_pc   = 32'h0;
    halt          = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    #1;
    check("rst_req", m.imem_req, 0);
    check("rst_addr", m.imem_addr, 32'h8000_0000);
    check("rst_addr2", m2.imem_addr, 32'hFFFF_FFFC);
    check("rst_vld", inst_valid, 0);
    check("rst_inst", inst, 0);
    check("rst_pc", inst_pc, 0);
    check("rst_fault", fault, 0);
    check("rst_fault2", fault2, 0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  logic [31:0] mpc, paddr, rd, rpc;
  logic        pending, gnt, rv, rdy, rd_en;
  int          cnt, consumed, since_rst;

  initial begin
    reset = 1'b0;
    idle_inputs();
    @(negedge clock);
    do_reset();

    // first fetch after reset, plus the wrapping instance in lock-step
    check("idle_req", m.imem_req, 0);
    tick();
    check("first_req", m.imem_req, 1);
    check("first_addr", m.imem_addr, 32'h8000_0000);
    check("wrap_first", m2.imem_addr, 32'hFFFF_FFFC);
    m.imem_gnt = 1'b1; inst_ready = 1'b1;
    tick();
    check("wait_req", m.imem_req, 0);
    m.imem_gnt = 1'b0; m.imem_rvalid = 1'b1; m.imem_rdata = 32'h0010_0093;
    tick();
    m.imem_rvalid = 1'b0;
    check("a_vld", inst_valid, 1);
    check("a_inst", inst, 32'h0010_0093);
    check("a_pc", inst_pc, 32'h8000_0000);
    check("wrap_vld", inst_valid2, 1);
    check("wrap_pc", inst_pc2, 32'hFFFF_FFFC);
    tick();
    check("a_next_req", m.imem_req, 1);
    check("a_next", m.imem_addr, 32'h8000_0004);
    check("wrap_next", m2.imem_addr, 32'h0000_0000);

    // decoder stalls for 5 cycles in HOLD
    m.imem_gnt = 1'b1; inst_ready = 1'b0;
    tick();
    m.imem_gnt = 1'b0; m.imem_rvalid = 1'b1; m.imem_rdata = 32'h00A0_0113;
    tick();
    m.imem_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("b_vld", inst_valid, 1);
      check("b_inst", inst, 32'h00A0_0113);
      check("b_pc", inst_pc, 32'h8000_0004);
      check("b_req", m.imem_req, 0);
      tick();
    end
    inst_ready = 1'b1;
    tick();
    check("b_next_req", m.imem_req, 1);
    check("b_next", m.imem_addr, 32'h8000_0008);

    // redirect coinciding with the response in WAIT
    m.imem_gnt = 1'b1;
    tick();
    m.imem_gnt = 1'b0; m.imem_rvalid = 1'b1; m.imem_rdata = 32'hDEAD_BEEF;
    redirect = 1'b1; redirect_pc = 32'h8000_0100;
    tick();
    m.imem_rvalid = 1'b0; redirect = 1'b0;
    check("c_vld", inst_valid, 0);
    check("c_req", m.imem_req, 1);
    check("c_addr", m.imem_addr, 32'h8000_0100);

    // halt pulse while waiting for the response
    m.imem_gnt = 1'b1;
    tick();
    m.imem_gnt = 1'b0; halt = 1'b1;
    tick();
    halt = 1'b0;
    check("d_wait_req", m.imem_req, 0);
    m.imem_rvalid = 1'b1; m.imem_rdata = 32'h0000_0013;
    tick();
    m.imem_rvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("d_vld", inst_valid, 0);
      check("d_req", m.imem_req, 0);
      m.imem_gnt = 1'b1; inst_ready = 1'b1;
      tick();
    end
    m.imem_gnt = 1'b0;

    // restart after reset; a stale response in IDLE/REQ is ignored
    do_reset();
    m.imem_rvalid = 1'b1; m.imem_rdata = 32'hBAD0_BAD0;
    tick();
    check("r_req", m.imem_req, 1);
    check("r_addr", m.imem_addr, 32'h8000_0000);
    tick();
    m.imem_rvalid = 1'b0;
    check("r_vld", inst_valid, 0);
    check("r_req2", m.imem_req, 1);

    // misaligned redirect: sticky fault, fetch stops for good
    redirect = 1'b1; redirect_pc = 32'h8000_0102;
    tick();
    check("e_fault", fault, 1);
    check("e_req", m.imem_req, 0);
    for (int i = 0; i < 5; i++) begin
      redirect = 1'b1; redirect_pc = 32'h8000_0200;
      m.imem_gnt = 1'b1; m.imem_rvalid = 1'b1; inst_ready = 1'b1;
      tick();
      check("e_stop_req", m.imem_req, 0);
      check("e_stop_vld", inst_valid, 0);
      check("e_fault_sticky", fault, 1);
    end
    do_reset();

    // halt and misaligned redirect together in HOLD: halt wins, no fault
    tick();
    m.imem_gnt = 1'b1;
    tick();
    m.imem_gnt = 1'b0; m.imem_rvalid = 1'b1; m.imem_rdata = 32'h0000_1234;
    tick();
    m.imem_rvalid = 1'b0;
    check("f_vld_hold", inst_valid, 1);
    halt = 1'b1; redirect = 1'b1; redirect_pc = 32'h8000_0102;
    tick();
    halt = 1'b0; redirect = 1'b0;
    check("f_fault", fault, 0);
    check("f_vld", inst_valid, 0);
    check("f_req", m.imem_req, 0);
    tick();
    check("f_req_stop", m.imem_req, 0);
    do_reset();

    // randomized run: memory with random grant/latency, random ready and redirects
    mpc = 32'h8000_0000; pending = 1'b0; consumed = 0; since_rst = 0; cnt = 0;
    paddr = 32'h0; rd = 32'h0;
    for (int c = 0; c < 2000; c++) begin
      if (c == 1000) begin
        do_reset();
        mpc = 32'h8000_0000; pending = 1'b0; since_rst = 0;
      end
      check("one_out", m.imem_req && pending, 0);
      if (inst_valid) begin
        check("rnd_pc", inst_pc, mpc);
        check("rnd_inst", inst, memf(mpc));
        check("rnd_vld_req", m.imem_req, 0);
      end
      rv = 1'b0;
      if (pending) begin
        cnt--;
        if (cnt == 0) begin
          rv = 1'b1; pending = 1'b0; rd = memf(paddr);
        end
      end
      gnt = 1'b0;
      if (m.imem_req && ($urandom_range(9, 0) < 7)) begin
        gnt = 1'b1;
        check("rnd_addr", m.imem_addr, mpc);
        pending = 1'b1; paddr = m.imem_addr; cnt = int'($urandom_range(3, 1));
      end
      rdy   = ($urandom_range(9, 0) < 6);
      rd_en = (since_rst > 2) && ($urandom_range(15, 0) == 0);
      rpc   = $urandom & 32'hFFFF_FFFC;
      if (rd_en) begin
        mpc = rpc;
      end else if (inst_valid && rdy) begin
        mpc = mpc + 32'd4;
        consumed++;
      end
      m.imem_gnt = gnt; m.imem_rvalid = rv; m.imem_rdata = rv ? rd : $urandom;
      inst_ready = rdy; redirect = rd_en; redirect_pc = rpc;
      tick();
      since_rst++;
    end
    check("rnd_progress", consumed > 50, 1);
    check("rnd_no_fault", fault, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
